// File: rtl/button_event_queue_if.sv
// Handshake bundle between the button event queue and its consumer.
//   btn_pulse : one-cycle press pulses, bit i = button i
//   pop       : consumer takes the head event this cycle
//   clr_ovf   : clears the sticky overflow flag
//   evt_valid : queue not empty, head event is on evt_id
//   evt_id    : button ID of the head event (show-ahead)
//   count     : queue occupancy, 0..DEPTH
//   overflow  : sticky, at least one press was dropped
// The master modport is the producer/consumer side; the slave modport is the queue.
interface button_event_queue_if #(
  parameter int NUM_BTN = 4,
  parameter int ID_W    = 2,
  parameter int AW      = 3
);
  logic [NUM_BTN-1:0] btn_pulse;
  logic               pop;
  logic               clr_ovf;
  logic               evt_valid;
  logic [ID_W-1:0]    evt_id;
  logic [AW:0]        count;
  logic               overflow;

  modport master (
    output btn_pulse, pop, clr_ovf,
    input  evt_valid, evt_id, count, overflow
  );

  modport slave (
    input  btn_pulse, pop, clr_ovf,
    output evt_valid, evt_id, count, overflow
  );
endinterface

// File: rtl/button_event_queue.sv
// Button event queue: turns single-cycle press pulses from NUM_BTN buttons into
// button-ID events in a show-ahead FIFO. Each press first lands in a per-button
// pending flag; one pending button (lowest ID first) is moved into the FIFO per
// cycle whenever there is room, so simultaneous presses are serialized and a
// full FIFO only loses a press when the same button is pressed again.
// Ports:
//   clk_in : system clock, rising edge
//   rst    : asynchronous reset, active low, clears all state
//   bus    : slave side of button_event_queue_if (pulses, pop, clr_ovf in;
//            evt_valid, evt_id, count, overflow out)
module button_event_queue #(
  parameter int NUM_BTN = 4,
  parameter int ID_W    = 2,
  parameter int DEPTH   = 8,
  parameter int AW      = 3
) (
  input logic                clk_in,
  input logic                rst,
  button_event_queue_if.slave bus
);

  logic [NUM_BTN-1:0] pend_reg;
  logic [NUM_BTN-1:0] pend_next;
  logic [NUM_BTN-1:0] push_sel;
  logic [NUM_BTN-1:0] drop;
  logic [ID_W-1:0]    mem_reg [DEPTH];
  logic [AW-1:0]      wr_ptr_reg;
  logic [AW-1:0]      rd_ptr_reg;
  logic [AW:0]        count_reg;
  logic [AW:0]        count_next;
  logic               ovf_reg;
  logic               ovf_next;
  logic [ID_W-1:0]    sel;
  logic               any_pend;
  logic               pop_ok;
  logic               push;

  // Lowest-ID pending button wins: scan downwards so the last hit is the lowest.
  always_comb begin
    sel = '0;
    for (int i = NUM_BTN - 1; i >= 0; i--) begin
      if (pend_reg[i]) sel = ID_W'(i);
    end
  end

  assign any_pend = |pend_reg;
  assign pop_ok   = bus.pop && (count_reg != '0);
  // A pop in the same cycle frees the slot, so a full FIFO can still accept.
  assign push     = any_pend && ((count_reg != (AW+1)'(DEPTH)) || pop_ok);

  generate
    for (genvar gi = 0; gi < NUM_BTN; gi++) begin : g_btn
      assign push_sel[gi]  = push && (sel == ID_W'(gi));
      // A new pulse on the button being pushed re-arms its flag: no press lost.
      assign pend_next[gi] = (pend_reg[gi] & ~push_sel[gi]) | bus.btn_pulse[gi];
      assign drop[gi]      = bus.btn_pulse[gi] & pend_reg[gi] & ~push_sel[gi];
    end
  endgenerate

  always_comb begin
    count_next = count_reg;
    case ({push, pop_ok})
      2'b10:   count_next = count_reg + 1'b1;
      2'b01:   count_next = count_reg - 1'b1;
      default: count_next = count_reg;
    endcase
  end

  // A drop in the same cycle beats a clear request.
  always_comb begin
    ovf_next = ovf_reg;
    if (|drop)            ovf_next = 1'b1;
    else if (bus.clr_ovf) ovf_next = 1'b0;
  end

  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst) begin
      pend_reg   <= '0;
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      ovf_reg    <= 1'b0;
      // Storage is cleared too so evt_id reads 0 straight out of reset.
      for (int i = 0; i < DEPTH; i++) mem_reg[i] <= '0;
    end else begin
      pend_reg  <= pend_next;
      count_reg <= count_next;
      ovf_reg   <= ovf_next;
      if (push) begin
        mem_reg[wr_ptr_reg] <= sel;
        wr_ptr_reg          <= wr_ptr_reg + 1'b1;
      end
      if (pop_ok) rd_ptr_reg <= rd_ptr_reg + 1'b1;
    end
  end

  assign bus.evt_valid = (count_reg != '0);
  assign bus.evt_id    = mem_reg[rd_ptr_reg];
  assign bus.count     = count_reg;
  assign bus.overflow  = ovf_reg;

endmodule

// File: tb/tb_button_event_queue.sv
module tb_button_event_queue;
  localparam int NB = 4;
  localparam int IW = 2;
  localparam int DP = 8;
  localparam int AW = 3;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  button_event_queue_if #(.NUM_BTN(NB), .ID_W(IW), .AW(AW)) bus ();

  button_event_queue #(.NUM_BTN(NB), .ID_W(IW), .DEPTH(DP), .AW(AW)) dut (
    .clk_in (clk),
    .rst    (rst),
    .bus    (bus)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: pending presses as a flag array, the FIFO as a queue.
  bit m_pend [NB];
  int m_q [$];
  bit m_ovf;

  typedef struct {
    logic [3:0] btn;
    bit         pop;
    bit         clr;
    bit         valid;
    int         id;
    int         cnt;
    bit         ovf;
  } vec_t;

  vec_t vt [21];

  function automatic vec_t mk(logic [3:0] b, bit p, bit c, bit v, int id, int n, bit o);
    vec_t r;
    r.btn = b; r.pop = p; r.clr = c; r.valid = v; r.id = id; r.cnt = n; r.ovf = o;
    return r;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    for (int i = 0; i < NB; i++) m_pend[i] = 1'b0;
    m_ovf = 1'b0;
  endtask

  // One clock edge worth of the queue's rules, evaluated on the pre-edge state.
  task automatic model_step(input logic [3:0] b, input bit p, input bit c);
    int  sel;
    bit  pop_ok;
    bit  do_push;
    bit  dropped;
    sel = -1;
    dropped = 1'b0;
    pop_ok = p && (m_q.size() > 0);
    for (int i = 0; i < NB; i++) if (m_pend[i] && sel < 0) sel = i;
    do_push = (sel >= 0) && ((m_q.size() < DP) || pop_ok);
    if (pop_ok) void'(m_q.pop_front());
    if (do_push) begin
      m_q.push_back(sel);
      m_pend[sel] = 1'b0;
    end
    for (int i = 0; i < NB; i++) begin
      if (b[i]) begin
        if (m_pend[i]) dropped = 1'b1;
        m_pend[i] = 1'b1;
      end
    end
    if (dropped) m_ovf = 1'b1;
    else if (c)  m_ovf = 1'b0;
  endtask

  // Drive on the falling edge, sample 1 time unit after the rising edge.
  task automatic drive(input logic [3:0] b, input bit p, input bit c);
    @(negedge clk);
    bus.btn_pulse = b;
    bus.pop       = p;
    bus.clr_ovf   = c;
    model_step(b, p, c);
    @(posedge clk);
    #1;
  endtask

  task automatic cmp_model(input string tag);
    chk({tag, " valid"}, int'(bus.evt_valid), int'(m_q.size() > 0));
    chk({tag, " count"}, int'(bus.count), m_q.size());
    chk({tag, " ovf"}, int'(bus.overflow), int'(m_ovf));
    if (m_q.size() > 0) chk({tag, " id"}, int'(bus.evt_id), m_q[0]);
  endtask

  task automatic do_reset();
    @(negedge clk);
    bus.btn_pulse = '0;
    bus.pop       = 1'b0;
    bus.clr_ovf   = 1'b0;
    rst = 1'b0;
    model_reset();
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    bus.btn_pulse = '0;
    bus.pop       = 1'b0;
    bus.clr_ovf   = 1'b0;
    model_reset();

    // Power-on reset state
    repeat (2) @(negedge clk);
    chk("rst valid", int'(bus.evt_valid), 0);
    chk("rst count", int'(bus.count), 0);
    chk("rst ovf", int'(bus.overflow), 0);
    chk("rst id", int'(bus.evt_id), 0);
    rst = 1'b1;

    // Vector table: single press, simultaneous presses, empty pop, re-press, drop/clear
    vt[0]  = mk(4'b0100, 0, 0, 0, 0, 0, 0);
    vt[1]  = mk(4'b0000, 0, 0, 1, 2, 1, 0);
    vt[2]  = mk(4'b0000, 1, 0, 0, 0, 0, 0);
    vt[3]  = mk(4'b1011, 0, 0, 0, 0, 0, 0);
    vt[4]  = mk(4'b0000, 0, 0, 1, 0, 1, 0);
    vt[5]  = mk(4'b0000, 0, 0, 1, 0, 2, 0);
    vt[6]  = mk(4'b0000, 0, 0, 1, 0, 3, 0);
    vt[7]  = mk(4'b0000, 1, 0, 1, 1, 2, 0);
    vt[8]  = mk(4'b0000, 1, 0, 1, 3, 1, 0);
    vt[9]  = mk(4'b0000, 1, 0, 0, 0, 0, 0);
    vt[10] = mk(4'b0000, 1, 0, 0, 0, 0, 0);
    vt[11] = mk(4'b0001, 0, 0, 0, 0, 0, 0);
    vt[12] = mk(4'b0001, 0, 0, 1, 0, 1, 0);
    vt[13] = mk(4'b0000, 0, 0, 1, 0, 2, 0);
    vt[14] = mk(4'b0000, 1, 0, 1, 0, 1, 0);
    vt[15] = mk(4'b0000, 1, 0, 0, 0, 0, 0);
    vt[16] = mk(4'b0011, 0, 0, 0, 0, 0, 0);
    vt[17] = mk(4'b0010, 0, 0, 1, 0, 1, 1);
    vt[18] = mk(4'b0000, 0, 1, 1, 0, 2, 0);
    vt[19] = mk(4'b0000, 1, 0, 1, 1, 1, 0);
    vt[20] = mk(4'b0000, 1, 0, 0, 0, 0, 0);

    for (int r = 0; r < 21; r++) begin
      drive(vt[r].btn, vt[r].pop, vt[r].clr);
      $display("row %0d btn=%b pop=%0d clr=%0d -> valid=%0d id=%0d count=%0d ovf=%0d",
               r, vt[r].btn, vt[r].pop, vt[r].clr,
               bus.evt_valid, bus.evt_id, bus.count, bus.overflow);
      chk($sformatf("row%0d valid", r), int'(bus.evt_valid), int'(vt[r].valid));
      chk($sformatf("row%0d count", r), int'(bus.count), vt[r].cnt);
      chk($sformatf("row%0d ovf", r), int'(bus.overflow), int'(vt[r].ovf));
      if (vt[r].valid) chk($sformatf("row%0d id", r), int'(bus.evt_id), vt[r].id);
    end

    // Asynchronous reset mid-stream with count=5 and overflow set
    do_reset();
    drive(4'b0011, 0, 0);
    drive(4'b0010, 0, 0);
    drive(4'b0000, 0, 0);
    drive(4'b0111, 0, 0);
    drive(4'b0000, 0, 0);
    drive(4'b0000, 0, 0);
    drive(4'b0000, 0, 0);
    chk("pre-rst count", int'(bus.count), 5);
    chk("pre-rst ovf", int'(bus.overflow), 1);
    #2 rst = 1'b0;
    #1;
    chk("async rst count", int'(bus.count), 0);
    chk("async rst valid", int'(bus.evt_valid), 0);
    chk("async rst ovf", int'(bus.overflow), 0);
    chk("async rst id", int'(bus.evt_id), 0);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    drive(4'b1000, 0, 0);
    chk("post-rst edge1 valid", int'(bus.evt_valid), 0);
    drive(4'b0000, 0, 0);
    chk("post-rst edge2 valid", int'(bus.evt_valid), 1);
    chk("post-rst edge2 id", int'(bus.evt_id), 3);

    // Full FIFO: pending flag holds the 9th press, push+pop at full
    do_reset();
    for (int k = 0; k < 8; k++) drive(4'(1 << (k % 4)), 0, 0);
    drive(4'b0000, 0, 0);
    chk("full count", int'(bus.count), 8);
    drive(4'b0010, 0, 0);
    drive(4'b0000, 0, 0);
    chk("held count", int'(bus.count), 8);
    cmp_model("held");
    drive(4'b0000, 1, 0);
    chk("push+pop full count", int'(bus.count), 8);
    chk("push+pop full ovf", int'(bus.overflow), 0);
    cmp_model("push+pop full");

    // Drop and overflow set/clear priority
    drive(4'b0010, 0, 0);
    drive(4'b0010, 0, 0);
    chk("drop ovf", int'(bus.overflow), 1);
    drive(4'b0000, 0, 1);
    chk("clr ovf", int'(bus.overflow), 0);
    drive(4'b0010, 0, 1);
    chk("set beats clr", int'(bus.overflow), 1);
    cmp_model("drop seq");

    // Pointer wrap with push/pop pairs, then pop on empty
    do_reset();
    for (int k = 0; k < 20; k++) begin
      drive(4'(1 << (k % 4)), 0, 0);
      drive(4'b0000, 0, 0);
      chk($sformatf("wrap%0d id", k), int'(bus.evt_id), k % 4);
      chk($sformatf("wrap%0d count", k), int'(bus.count), 1);
      drive(4'b0000, 1, 0);
      chk($sformatf("wrap%0d empty", k), int'(bus.count), 0);
    end
    drive(4'b0000, 1, 0);
    chk("empty pop count", int'(bus.count), 0);
    chk("empty pop valid", int'(bus.evt_valid), 0);

    // Randomized traffic against the model; pop rate varies to reach full and empty
    do_reset();
    for (int n = 0; n < 600; n++) begin
      logic [3:0] b;
      bit p;
      bit c;
      b = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(0, 15)) : 4'b0000;
      if (n < 200)      p = ($urandom_range(0, 7) == 0);
      else if (n < 400) p = ($urandom_range(0, 1) == 0);
      else              p = ($urandom_range(0, 7) != 0);
      c = ($urandom_range(0, 9) == 0);
      drive(b, p, c);
      cmp_model($sformatf("rand%0d", n));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
